// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the boot-ROM access arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic port_id_t;

  localparam int unsigned ROM_LAT_DEFAULT = 2;

endpackage

// File: rtl/rom_access_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: on contention the port that did not win last time is granted.
module rr_arb2
  import rom_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  port_id_t   last_grant,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = valid;
    if (valid == 2'b11) begin
      grant_c = (last_grant == 1'b1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares the boot ROM macro between the I-fetch refill port (0) and the AHB data port (1),
// sequencing enable/OE for a fixed latency and returning data on a per-port response strobe.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROM_AW  = 12,
  parameter int unsigned ROM_LAT = ROM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic              ROM_enable,
  output logic              ROM_OE,
  output logic [ROM_AW-1:0] ROM_address,
  input  logic [DATA_W-1:0] ROM_out,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(ROM_LAT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  port_id_t          last_grant_q, last_grant_d;
  port_id_t          port_q, port_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [1:0]        grant_c;
  logic              hs_c;
  port_id_t          win_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic              unused_addr_c;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant_c    (grant_c)
  );

  // Ready is offered only in IDLE and is forced low while reset is asserted.
  assign req0_ready = rst && (state_q == IDLE) && grant_c[0];
  assign req1_ready = rst && (state_q == IDLE) && grant_c[1];
  assign hs_c       = req0_ready || req1_ready;
  assign win_c      = port_id_t'(grant_c[1]);
  assign sel_addr_c = grant_c[1] ? req1_addr : req0_addr;
  assign unused_addr_c = ^{sel_addr_c[ADDR_W-1:ROM_AW+2]};

  assign ROM_enable  = (state_q == ACCESS);
  assign ROM_OE      = (state_q == ACCESS);
  assign ROM_address = rom_addr_q;
  assign busy        = (state_q != IDLE);
  assign rsp0_valid  = (state_q == RESP) && (port_q == 1'b0);
  assign rsp1_valid  = (state_q == RESP) && (port_q == 1'b1);
  assign rsp0_data   = data_q;
  assign rsp1_data   = data_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      rom_addr_q   <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      rom_addr_q   <= rom_addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  // Misaligned requests skip the ROM entirely; ROM_address keeps its last driven value.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    rom_addr_d   = rom_addr_q;
    data_d       = data_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (hs_c) begin
          last_grant_d = win_c;
          port_d       = win_c;
          if (sel_addr_c[1:0] != 2'b00) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = RESP;
          end else begin
            err_d      = 1'b0;
            rom_addr_d = sel_addr_c[ROM_AW+1:2];
            cnt_d      = CNT_W'(ROM_LAT - 1);
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          data_d  = ROM_out;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  a_rom_lat: assert property (@(posedge clk) ROM_LAT >= 1);
  a_hold0: assert property (@(posedge clk) disable iff (!rst)
    (req0_valid && !req0_ready) |=> (req0_valid && $stable(req0_addr)));
  a_hold1: assert property (@(posedge clk) disable iff (!rst)
    (req1_valid && !req1_ready) |=> (req1_valid && $stable(req1_addr)));
  a_one_ready: assert property (@(posedge clk) disable iff (!rst) !(req0_ready && req1_ready));
  a_one_rsp: assert property (@(posedge clk) disable iff (!rst) !(rsp0_valid && rsp1_valid));

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Scoreboard bench for rom_access_arbiter: drivers push expected responses, a negedge monitor checks them.
module tb_rom_access_arbiter;
  import rom_arb_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;

  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data, rom_out;
  logic        rom_enable, rom_oe, busy;
  logic [11:0] rom_address;

  logic        req0_valid_b = 1'b0;
  logic [31:0] req0_addr_b = '0;
  logic        req0_ready_b, req1_ready_b, rsp0_valid_b, rsp1_valid_b, rsp0_err_b, rsp1_err_b;
  logic [31:0] rsp0_data_b, rsp1_data_b, rom_out_b;
  logic        rom_enable_b, rom_oe_b, busy_b;
  logic [11:0] rom_address_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: word i reads as A500_0000+i while OE is asserted.
  assign rom_out   = rom_oe   ? 32'hA500_0000 + 32'(rom_address)   : 32'h0;
  assign rom_out_b = rom_oe_b ? 32'hA500_0000 + 32'(rom_address_b) : 32'h0;

  rom_access_arbiter #(.ROM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .ROM_enable(rom_enable), .ROM_OE(rom_oe), .ROM_address(rom_address),
    .ROM_out(rom_out), .busy(busy)
  );

  rom_access_arbiter #(.ROM_LAT(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid_b), .req0_addr(req0_addr_b), .req0_ready(req0_ready_b),
    .rsp0_valid(rsp0_valid_b), .rsp0_data(rsp0_data_b), .rsp0_err(rsp0_err_b),
    .req1_valid(1'b0), .req1_addr(32'h0), .req1_ready(req1_ready_b),
    .rsp1_valid(rsp1_valid_b), .rsp1_data(rsp1_data_b), .rsp1_err(rsp1_err_b),
    .ROM_enable(rom_enable_b), .ROM_OE(rom_oe_b), .ROM_address(rom_address_b),
    .ROM_out(rom_out_b), .busy(busy_b)
  );

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   last_gnt = 1'b1;
  bit   en_seen = 1'b0;
  int   rsp_cnt = 0;
  int   last_rsp_cyc = -10;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor plus round-robin and busy-gap model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_gnt = 1'b1;
    end else begin
      if (rom_enable) en_seen = 1'b1;
      if (req0_ready || req1_ready) begin
        check("one_ready", 64'(req0_ready & req1_ready), 64'd0);
        if (req0_valid && req1_valid) check("rr_grant", 64'(req1_ready), 64'(!last_gnt));
        last_gnt = req1_ready;
      end
      if (cyc == last_rsp_cyc + 1) check("gap_idle", 64'(busy), 64'd0);
      if (cyc == last_rsp_cyc + 2 && sb.size() != 0) check("gap_busy", 64'(busy), 64'd1);
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp0=%0b rsp1=%0b with empty queue (cycle %0d)",
                   rsp0_valid, rsp1_valid, cyc);
        end else begin
          e = sb.pop_front();
          check("rsp_both", 64'(rsp0_valid & rsp1_valid), 64'd0);
          check("rsp_port", 64'(rsp1_valid), 64'(e.port));
          check("rsp_data", 64'(e.port ? rsp1_data : rsp0_data), 64'(e.data));
          check("rsp_err", 64'(e.port ? rsp1_err : rsp0_err), 64'(e.err));
          check("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
        last_rsp_cyc = cyc;
        rsp_cnt++;
      end
    end
  end

  // Present one request; called at posedge+1. Returns the handshake cycle in hs.
  task automatic issue(input bit port, input logic [31:0] addr, input bit expect_rsp,
                       input bit hold_after, output int hs);
    exp_t e;
    bit   got;
    bit   err;
    got = 1'b0;
    hs  = -1;
    if (port) begin req1_addr = addr; req1_valid = 1'b1; end
    else      begin req0_addr = addr; req0_valid = 1'b1; end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) begin
        got = 1'b1;
        hs  = cyc;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: port %0d addr %0h never accepted", port, addr);
    end else if (expect_rsp) begin
      err    = (addr[1:0] != 2'b00);
      e.port = port;
      e.err  = err;
      e.data = err ? 32'h0 : 32'hA500_0000 + 32'(addr[13:2]);
      e.cyc  = hs + (err ? 1 : int'(LAT) + 1);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold_after || !got) begin
      if (port) req1_valid = 1'b0;
      else      req0_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int h0, h1, t, n;

    // Reset state
    #12;
    check("rst_outputs", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                              rom_enable, rom_oe, busy}), 64'd0);
    check("rst_data", 64'({rsp0_data, rsp1_data}), 64'd0);
    check("rst_rom_addr", 64'(rom_address), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Both valid straight after reset: port0 first, port1 four cycles later
    fork
      issue(1'b0, 32'h0000_0000, 1'b1, 1'b0, h0);
      issue(1'b1, 32'h0000_0008, 1'b1, 1'b0, h1);
    join
    check("t2_accept_gap", 64'(h1 - h0), 64'd4);
    drain();

    // Single read, ROM pin timing
    req0_addr = 32'h10;
    req0_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if (req0_ready) t = cyc;
    end
    check("t1_accept", 64'(t >= 0), 64'd1);
    sb.push_back('{port: 1'b0, data: 32'hA500_0004, err: 1'b0, cyc: t + 3});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t1_en_oe", 64'({rom_enable, rom_oe}), 64'h3);
      check("t1_rom_addr", 64'(rom_address), 64'h4);
    end
    @(negedge clk);
    check("t1_en_off", 64'({rom_enable, rom_oe}), 64'h0);
    check("t1_addr_hold", 64'(rom_address), 64'h4);
    drain();

    // Continuous contention: strict alternation, one idle cycle between accesses
    n = rsp_cnt;
    fork
      for (int i = 0; i < 4; i++) issue(1'b0, 32'h100 + 32'(16 * i), 1'b1, i < 3, h0);
      for (int i = 0; i < 4; i++) issue(1'b1, 32'h200 + 32'(4 * i), 1'b1, i < 3, h1);
    join
    drain();
    check("t3_rsp_count", 64'(rsp_cnt - n), 64'd8);

    // Misaligned address: error response next cycle, ROM untouched
    en_seen = 1'b0;
    issue(1'b1, 32'h13, 1'b1, 1'b0, h1);
    drain();
    check("t4_no_rom", 64'(en_seen), 64'd0);

    // Reset during the second ACCESS cycle drops the transaction
    issue(1'b0, 32'h20, 1'b0, 1'b0, h0);
    req0_addr = 32'h30; req0_valid = 1'b1;
    req1_addr = 32'h34; req1_valid = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t5_outputs", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                             rom_enable, rom_oe, busy}), 64'd0);
    check("t5_rom_addr", 64'(rom_address), 64'd0);
    check("t5_data", 64'({rsp0_data, rsp1_data}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_no_rsp", 64'({rsp0_valid, rsp1_valid, busy}), 64'd0);
    rst = 1'b1;
    fork
      issue(1'b0, 32'h30, 1'b1, 1'b0, h0);
      issue(1'b1, 32'h34, 1'b1, 1'b0, h1);
    join
    check("t5_port0_first", 64'(h1 - h0), 64'd4);
    drain();

    // ROM_LAT=1 instance
    req0_addr_b = 32'h40;
    req0_valid_b = 1'b1;
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if (req0_ready_b) t = cyc;
    end
    check("t6_accept", 64'(t >= 0), 64'd1);
    @(posedge clk); #1;
    req0_valid_b = 1'b0;
    @(negedge clk);
    check("t6_access", 64'({rom_enable_b, rsp0_valid_b}), 64'h2);
    check("t6_rom_addr", 64'(rom_address_b), 64'h10);
    @(negedge clk);
    check("t6_rsp_valid", 64'({rsp0_valid_b, rsp1_valid_b}), 64'h2);
    check("t6_rsp_cycle", 64'(cyc - t), 64'd2);
    check("t6_rsp_data", 64'(rsp0_data_b), 64'hA500_0010);
    check("t6_rsp_err", 64'(rsp0_err_b), 64'd0);
    @(negedge clk);
    check("t6_idle", 64'({busy_b, rsp0_valid_b}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
